input_vc_buffer: RTL
====================

Name: input_vc_buffer

Overview:
- Per-input-port virtual-channel flit buffer that sits directly upstream of the local switch-allocation stage.
- Stores incoming flits in one FIFO per VC and presents each VC's head flit and head-valid to local switch allocation.
- Pops the VC named by the switch-allocation read enable and returns one credit per popped flit to the upstream router.

Parameters:
- VC_NUM, 4, number of virtual channels (FIFOs) per input port; must be >= 2.
- VC_IDX_W, (VC_NUM>1 ? clog2(VC_NUM) : 1), VC index width.
- VC_DEPTH, 2, flit entries per VC FIFO; must be >= 1; need not be a power of 2.
- FLIT_W, 33, flit width. Bits [3:0] are QoS value, bits [6:4] are look-ahead output port, bits [FLIT_W-1:7] are opaque.

Ports:
- clk, input, 1, clock.
- rstn, input, 1, asynchronous active-low reset.
- flit_vld_i, input, 1, incoming flit valid. No ready signal; the upstream router is credit-controlled.
- flit_i, input, FLIT_W, incoming flit.
- flit_vc_id_i, input, VC_IDX_W, target VC of the incoming flit.
- rd_en_i, input, 1, pop request (inport read enable from the switch-allocation stage).
- rd_vc_id_oh_i, input, VC_NUM, one-hot VC to pop.
- vc_head_vld_o, output, VC_NUM, bit v = VC v is non-empty.
- vc_head_o, output, VC_NUM*FLIT_W, slice v = head flit of VC v.
- credit_vld_o, output, 1, credit return pulse.
- credit_vc_id_o, output, VC_IDX_W, VC of the returned credit.
- vc_full_o, output, VC_NUM, bit v = VC v holds VC_DEPTH flits.
- err_o, output, 1, sticky protocol error flag.

Behaviour:
- Reset (asynchronous, rstn low):
  - All read pointers, write pointers and counts go to 0.
  - vc_head_vld_o=0, vc_full_o=0, credit_vld_o=0, credit_vc_id_o=0, err_o=0.
  - Storage contents are don't-care; no reset is required on the flit array.
  - Reset asserted mid-traffic discards all stored flits and drops any pending credit.
- Per-VC state: wr_ptr and rd_ptr of width clog2(VC_DEPTH) (minimum 1 bit), plus cnt of width clog2(VC_DEPTH+1).
- Pointer wrap: a pointer equal to VC_DEPTH-1 wraps to 0 on increment. Wrap is explicit compare, not modulo 2^n.
- Push:
  - Occurs when flit_vld_i=1 and cnt[flit_vc_id_i] < VC_DEPTH.
  - Writes flit_i at wr_ptr, then wr_ptr++ and cnt++.
- Pop:
  - Occurs when rd_en_i=1, rd_vc_id_oh_i is exactly one-hot, and the selected cnt > 0.
  - rd_ptr++ and cnt--.
- Simultaneous push and pop on the same VC:
  - Both take effect and cnt is unchanged.
  - This is legal even when cnt==VC_DEPTH: the push is accepted because a slot is freed the same cycle.
- Latency:
  - A flit pushed at cycle t is visible on vc_head_vld_o/vc_head_o at t+1. There is no same-cycle bypass.
  - A pop at cycle t updates the head at t+1.
- vc_head_o slice v is driven combinationally from storage[v][rd_ptr[v]]. It is valid only while vc_head_vld_o[v]=1.
- vc_head_vld_o[v] = (cnt[v] != 0), and vc_full_o[v] = (cnt[v] == VC_DEPTH). Both are derived from registered state only.
- Credit return:
  - Registered: a successful pop at t gives credit_vld_o=1 at t+1 with credit_vc_id_o = index of the popped VC.
  - credit_vld_o is 0 in any cycle that does not follow a pop.
  - credit_vc_id_o holds its last value when credit_vld_o=0.
- Errors (each sets err_o=1 on the next edge; err_o stays 1 until reset):
  - Push to a full VC without a same-VC pop: the flit is dropped and state is unchanged.
  - Pop of an empty VC: ignored, no credit.
  - rd_en_i=1 with rd_vc_id_oh_i not one-hot (zero or multi-hot): no pop, no credit.
  - flit_vc_id_i >= VC_NUM while flit_vld_i=1: the flit is dropped.
- Independent VCs do not interact. A push to VC a and a pop of VC b in the same cycle both proceed.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset, then leave inputs idle.
  - Response: vc_head_vld_o=4'b0000, credit_vld_o=0, err_o=0, vc_full_o=4'b0000.
- Single flit, push then pop:
  - Stimulus: push flit 33'h1_0000_0025 to VC2 at t0.
  - Response: at t0+1, vc_head_vld_o=4'b0100 and vc_head_o slice 2 = 33'h1_0000_0025 (QoS=5, look-ahead port=2).
  - Stimulus: rd_en_i=1, rd_vc_id_oh_i=4'b0100 at t1.
  - Response: at t1+1, vc_head_vld_o=0, credit_vld_o=1, credit_vc_id_o=2.
- Fill, ordering and wrap:
  - Stimulus: push A then B to VC0; pop both; push C.
  - Response:
    - After A and B: vc_full_o[0]=1.
    - Pops return A then B in order.
    - C is the head after pointer wrap.
    - Two credits are returned, each with credit_vc_id_o=0.
- Simultaneous push and pop on a full VC:
  - Stimulus: VC1 holds X,Y; push Z while popping VC1.
  - Response: next cycle head=Y, vc_full_o[1]=1, err_o=0, credit for VC1.
- Overflow and illegal pops:
  - Stimulus: push to full VC3 without a pop.
  - Response: flit dropped, err_o=1, VC3 contents unchanged.
  - Stimulus: after reset, rd_en_i=1 with rd_vc_id_oh_i=4'b0011.
  - Response: no pop, no credit, err_o=1.
- Reset mid-operation and VC independence:
  - Stimulus: reset asserted with 3 VCs non-empty.
  - Response: vc_head_vld_o=0 immediately (asynchronous); no credit after release.
  - Stimulus: in the same cycle, push to VC0 and pop VC3.
  - Response: both succeed.

Source files
------------

// File: rtl/input_vc_buffer.sv
// Input-port virtual-channel flit buffer: one FIFO per VC feeding switch allocation,
// with a registered one-credit-per-pop return path and a sticky protocol error flag.
module input_vc_buffer #(
  parameter int VC_NUM   = 4,
  parameter int VC_IDX_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int VC_DEPTH = 2,
  parameter int FLIT_W   = 33
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flit_vld_i,
  input  logic [FLIT_W-1:0]          flit_i,
  input  logic [VC_IDX_W-1:0]        flit_vc_id_i,
  input  logic                       rd_en_i,
  input  logic [VC_NUM-1:0]          rd_vc_id_oh_i,
  output logic [VC_NUM-1:0]          vc_head_vld_o,
  output logic [VC_NUM*FLIT_W-1:0]   vc_head_o,
  output logic                       credit_vld_o,
  output logic [VC_IDX_W-1:0]        credit_vc_id_o,
  output logic [VC_NUM-1:0]          vc_full_o,
  output logic                       err_o
);

  localparam int PTR_W = (VC_DEPTH > 1) ? $clog2(VC_DEPTH) : 1;
  localparam int CNT_W = $clog2(VC_DEPTH + 1);
  localparam logic [CNT_W-1:0]    DEPTH_C  = CNT_W'(VC_DEPTH);
  localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(VC_DEPTH - 1);
  localparam logic [VC_IDX_W:0]   VC_NUM_C = (VC_IDX_W + 1)'(VC_NUM);

  logic                in_range;
  logic                rd_onehot;
  logic                pop_any;
  logic                err_reg;
  logic                err_next;
  logic                credit_vld_reg;
  logic [VC_IDX_W-1:0] credit_vc_reg;
  logic [VC_IDX_W-1:0] pop_idx;
  logic [VC_NUM-1:0]   pop_vec;
  logic [VC_NUM-1:0]   push_drop;
  logic [VC_NUM-1:0]   pop_empty;

  assign in_range  = ({1'b0, flit_vc_id_i} < VC_NUM_C);
  assign rd_onehot = (rd_vc_id_oh_i != '0) &&
                     ((rd_vc_id_oh_i & (rd_vc_id_oh_i - VC_NUM'(1))) == '0);

  genvar gi;
  generate
    for (gi = 0; gi < VC_NUM; gi++) begin : g_vc
      logic [FLIT_W-1:0] mem [VC_DEPTH];
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [CNT_W-1:0]  cnt_reg;
      logic              full;
      logic              push_req;
      logic              pop_req;
      logic              push_v;
      logic              pop_v;

      assign full     = (cnt_reg == DEPTH_C);
      assign push_req = flit_vld_i && in_range && (flit_vc_id_i == VC_IDX_W'(gi));
      assign pop_req  = rd_en_i && rd_onehot && rd_vc_id_oh_i[gi];
      assign pop_v    = pop_req && (cnt_reg != '0);
      // A same-cycle pop frees a slot, so a full VC still accepts the push.
      assign push_v   = push_req && (!full || pop_v);

      assign pop_vec[gi]   = pop_v;
      assign push_drop[gi] = push_req && !push_v;
      assign pop_empty[gi] = pop_req && (cnt_reg == '0);

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          cnt_reg    <= '0;
        end else begin
          if (push_v)
            wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
          if (pop_v)
            rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
          if (push_v && !pop_v)
            cnt_reg <= cnt_reg + CNT_W'(1);
          else if (pop_v && !push_v)
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (push_v)
          mem[wr_ptr_reg] <= flit_i;
      end

      assign vc_head_o[gi*FLIT_W +: FLIT_W] = mem[rd_ptr_reg];
      assign vc_head_vld_o[gi]              = (cnt_reg != '0);
      assign vc_full_o[gi]                  = full;
    end
  endgenerate

  assign pop_any = |pop_vec;

  always_comb begin
    pop_idx = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      if (rd_vc_id_oh_i[v])
        pop_idx = VC_IDX_W'(v);
    end
  end

  assign err_next = err_reg
                  | (flit_vld_i && !in_range)
                  | (rd_en_i && !rd_onehot)
                  | (|push_drop)
                  | (|pop_empty);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit_vld_reg <= 1'b0;
      credit_vc_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      credit_vld_reg <= pop_any;
      if (pop_any)
        credit_vc_reg <= pop_idx;
      err_reg <= err_next;
    end
  end

  assign credit_vld_o   = credit_vld_reg;
  assign credit_vc_id_o = credit_vc_reg;
  assign err_o          = err_reg;

endmodule
